// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: controller states, ALU opcodes and the default execution timeout
package alu_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, CLEAR, EXEC, RESP} stateT;
    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;
    localparam logic [3:0] MUL = 4'd2;
    localparam logic [3:0] DIV = 4'd3;
    localparam logic [3:0] ROT = 4'd12;
    localparam logic [3:0] ILLEGAL_MIN = 4'd13;
    localparam int DEFAULT_TIMEOUT = 100;
    function automatic logic isIllegal(input logic [3:0] op);
        return op >= ILLEGAL_MIN;
    endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, favours the requester not served last
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);
    logic lastId;
    always_ff @(posedge clk or negedge rst)
        if (!rst) lastId <= 1'b1;
        else if (accept) lastId <= grant[1];
    assign grant = (valid == 2'b11) ? (lastId ? 2'b01 : 2'b10) : valid;
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: shares one multi-cycle ALU between two requesters with a tagged response port
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req0_aluop,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_inv,
    input  logic        req0_inc,
    input  logic [3:0]  req1_aluop,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_inv,
    input  logic        req1_inc,
    output logic [3:0]  alu_aluop,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_inv,
    output logic        alu_inc,
    output logic        alu_rst,
    input  logic        alu_done,
    input  logic [31:0] alu_res_high,
    input  logic [31:0] alu_res_low,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic        rsp_err,
    output logic [31:0] rsp_high,
    output logic [31:0] rsp_low
);
    localparam int CW = $clog2(TIMEOUT + 1);
    stateT state, nextState;
    logic [CW-1:0] cnt;
    logic [1:0] grant;
    logic xfer, winId, timedOut;
    logic [3:0] winOp;
    rr_arb2 uArb (.clk(clk), .rst(rst), .valid(req_valid), .accept(xfer), .grant(grant));
    // ready is gated by rst so nothing is offered while reset is held
    assign req_ready = (rst && state == IDLE) ? grant : 2'b00;
    assign xfer = |(req_valid & req_ready);
    assign winId = grant[1];
    assign winOp = winId ? req1_aluop : req0_aluop;
    assign timedOut = cnt == CW'(TIMEOUT - 1);
    assign alu_rst = !rst || state == CLEAR;
    assign rsp_valid = state == RESP;
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:  nextState = xfer ? (isIllegal(winOp) ? RESP : CLEAR) : IDLE;
            CLEAR: nextState = EXEC;
            EXEC:  nextState = (alu_done || timedOut) ? RESP : EXEC;
            RESP:  nextState = rsp_ready ? IDLE : RESP;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            alu_aluop <= '0;
            alu_a <= '0;
            alu_b <= '0;
            alu_inv <= 1'b0;
            alu_inc <= 1'b0;
            rsp_id <= 1'b0;
            rsp_err <= 1'b0;
            rsp_high <= '0;
            rsp_low <= '0;
        end else begin
            state <= nextState;
            if (xfer) begin
                alu_aluop <= winOp;
                alu_a <= winId ? req1_a : req0_a;
                alu_b <= winId ? req1_b : req0_b;
                alu_inv <= winId ? req1_inv : req0_inv;
                alu_inc <= winId ? req1_inc : req0_inc;
                rsp_id <= winId;
            end
            if (state == CLEAR) cnt <= '0;
            else if (state == EXEC && cnt != CW'(TIMEOUT)) cnt <= cnt + CW'(1);
            if (xfer && isIllegal(winOp)) {rsp_err, rsp_high, rsp_low} <= {1'b1, 64'd0};
            else if (state == EXEC && alu_done) {rsp_err, rsp_high, rsp_low} <= {1'b0, alu_res_high, alu_res_low};
            else if (state == EXEC && timedOut) {rsp_err, rsp_high, rsp_low} <= {1'b1, 64'd0};
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vectors against a behavioural ALU with programmable done latency
module tb_alu_issue_ctrl;
    import alu_ctrl_pkg::*;
    logic clk = 1'b0, rst = 1'b0;
    logic [1:0] req_valid = 2'b00, req_ready;
    logic [3:0] req0_aluop = '0, req1_aluop = '0, alu_aluop;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [31:0] alu_a, alu_b, alu_res_high, alu_res_low, rsp_high, rsp_low;
    logic req0_inv = 1'b0, req0_inc = 1'b0, req1_inv = 1'b0, req1_inc = 1'b0;
    logic alu_inv, alu_inc, alu_rst, alu_done, rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_err;
    logic [63:0] aluRes;
    int nVec = 0, nBad = 0, execCnt = 0, doneAt = 1;
    int edges, rstSeen, stray;
    logic opsMoved;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req0_aluop(req0_aluop), .req0_a(req0_a), .req0_b(req0_b), .req0_inv(req0_inv), .req0_inc(req0_inc),
        .req1_aluop(req1_aluop), .req1_a(req1_a), .req1_b(req1_b), .req1_inv(req1_inv), .req1_inc(req1_inc),
        .alu_aluop(alu_aluop), .alu_a(alu_a), .alu_b(alu_b), .alu_inv(alu_inv), .alu_inc(alu_inc),
        .alu_rst(alu_rst), .alu_done(alu_done), .alu_res_high(alu_res_high), .alu_res_low(alu_res_low),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_high(rsp_high), .rsp_low(rsp_low)
    );

    // ALU model: done is raised in the doneAt-th cycle after alu_rst falls (0 = never)
    always @(posedge clk) execCnt <= alu_rst ? 0 : execCnt + 1;
    assign alu_done = !alu_rst && doneAt != 0 && execCnt == doneAt - 1;
    always_comb begin
        aluRes = '0;
        case (alu_aluop)
            ADD: aluRes = {32'd0, alu_a + alu_b};
            SUB: aluRes = {32'd0, alu_a - alu_b};
            MUL: aluRes = {32'd0, alu_a} * {32'd0, alu_b};
            DIV: aluRes = (alu_b == 0) ? 64'd0 : {alu_a % alu_b, alu_a / alu_b};
            default: aluRes = '0;
        endcase
    end
    assign {alu_res_high, alu_res_low} = aluRes;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nVec++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (id == 0) begin
            req0_aluop = op; req0_a = a; req0_b = b;
        end else begin
            req1_aluop = op; req1_a = a; req1_b = b;
        end
        req_valid = (id == 0) ? 2'b01 : 2'b10;
        #1;
        for (int i = 0; i < 10 && !req_ready[id]; i++) tick();
        chk("accept", 64'(req_ready[id]), 64'd1);
        tick();
        req_valid = 2'b00;
    endtask

    task automatic waitRsp(input int limit);
        logic [67:0] ops;
        ops = {alu_aluop, alu_a, alu_b};
        edges = 0; rstSeen = 0; opsMoved = 1'b0;
        while (!rsp_valid && edges < limit) begin
            if (alu_rst) rstSeen++;
            tick();
            edges++;
            if ({alu_aluop, alu_a, alu_b} != ops) opsMoved = 1'b1;
        end
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req_valid = 2'b11;
        #12;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_alu_rst", 64'(alu_rst), 64'd1);
        chk("rst_rsp", {29'd0, rsp_err, rsp_id, rsp_high, rsp_low}, 64'd0);
        chk("rst_drive", {alu_aluop, alu_a, alu_b, alu_inv, alu_inc}, 70'd0);
        req_valid = 2'b00;
        @(negedge clk) rst = 1'b1;
        tick();
        chk("idle_alu_rst", 64'(alu_rst), 64'd0);

        issue(0, ADD, 32'd5, 32'd7);
        waitRsp(10);
        chk("add_latency", 64'(edges), 64'd2);
        chk("add_result", {rsp_high, rsp_low}, 64'd12);
        chk("add_id_err", {rsp_id, rsp_err}, 64'd0);
        tick();
        chk("add_done", 64'(rsp_valid), 64'd0);

        req0_aluop = ADD; req0_a = 32'd1; req0_b = 32'd2;
        req1_aluop = SUB; req1_a = 32'd9; req1_b = 32'd4;
        req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            waitRsp(10);
            chk("rr_period", 64'(edges), 64'd3);
            chk("rr_id", 64'(rsp_id), (k % 2 == 0) ? 64'd1 : 64'd0);
            chk("rr_result", 64'(rsp_low), (k % 2 == 0) ? 64'd5 : 64'd3);
            if (k == 7) req_valid = 2'b00;
            tick();
        end

        doneAt = 34;
        issue(0, MUL, 32'h10000, 32'h10000);
        waitRsp(200);
        chk("mul_latency", 64'(edges), 64'd35);
        chk("mul_rst_pulse", 64'(rstSeen), 64'd1);
        chk("mul_ops_stable", 64'(opsMoved), 64'd0);
        chk("mul_result", {rsp_high, rsp_low}, 64'h1_0000_0000);
        chk("mul_err", 64'(rsp_err), 64'd0);
        tick();

        issue(1, 4'd14, 32'd3, 32'd4);
        waitRsp(5);
        chk("ill_latency", 64'(edges), 64'd0);
        chk("ill_rst_pulse", 64'(rstSeen), 64'd0);
        chk("ill_err_id", {rsp_err, rsp_id}, 64'd3);
        chk("ill_result", {rsp_high, rsp_low}, 64'd0);
        tick();

        doneAt = 0;
        issue(0, DIV, 32'd100, 32'd7);
        waitRsp(300);
        chk("tmo_latency", 64'(edges), 64'd101);
        chk("tmo_err", 64'(rsp_err), 64'd1);
        chk("tmo_result", {rsp_high, rsp_low}, 64'd0);
        tick();

        issue(0, MUL, 32'd3, 32'd4);
        repeat (5) tick();
        rst = 1'b0;
        #1;
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort_alu_rst", 64'(alu_rst), 64'd1);
        chk("abort_drive", {alu_aluop, alu_a, alu_b}, 68'd0);
        chk("abort_rsp", {30'd0, rsp_err, rsp_id, rsp_high, rsp_low}, 64'd0);
        tick();
        rst = 1'b1;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid) stray++;
        end
        chk("abort_no_rsp", 64'(stray), 64'd0);

        doneAt = 1;
        req0_aluop = ADD; req0_a = 32'd20; req0_b = 32'd22;
        req1_aluop = ADD; req1_a = 32'd1; req1_b = 32'd1;
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("ptr_reset", 64'(req_ready), 64'd1);
        tick();
        waitRsp(10);
        chk("stall_latency", 64'(edges), 64'd2);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("stall_hold", {rsp_valid, req_ready, rsp_id, rsp_err, rsp_low}, {1'b1, 2'b00, 1'b0, 1'b0, 32'd42});
        end
        rsp_ready = 1'b1;
        tick();
        chk("stall_release", 64'(rsp_valid), 64'd0);
        chk("stall_next_grant", 64'(req_ready), 64'd2);
        req_valid = 2'b00;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end
endmodule
